// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path.
// FSM states, element encoding, LUT key bundle and ASCII codes.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        WAIT_WORD
    } state_t;

    typedef enum logic {
        DOT  = 1'b0,
        DASH = 1'b1
    } elem_t;

    typedef logic [7:0] ascii_t;

    // LUT key: element count plus right-aligned pattern,
    // first element in the highest used bit.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } code_t;

    localparam ascii_t ASCII_SPACE   = 8'h20;
    localparam ascii_t ASCII_UNKNOWN = 8'h3F;

    localparam int unsigned MAX_ELEMS = 5;

endpackage

// File: rtl/morse_decoder_if.sv
// Key/tick inputs and decoded-character outputs of morse_decoder.
// master: drives i_tick/i_key; slave: the decoder.
interface morse_decoder_if;
    import morse_pkg::*;

    logic   i_tick;
    logic   i_key;
    ascii_t o_char;
    logic   o_valid;
    logic   o_busy;

    modport master (
        output i_tick,
        output i_key,
        input  o_char,
        input  o_valid,
        input  o_busy
    );

    modport slave (
        input  i_tick,
        input  i_key,
        output o_char,
        output o_valid,
        output o_busy
    );

endinterface

// File: rtl/morse_lut.sv
// Combinational ITU Morse lookup for A-Z and 0-9.
// i_code {len, pattern} in, o_ascii out ('?' on a miss).
module morse_lut
    import morse_pkg::*;
(
    input  code_t  i_code,
    output ascii_t o_ascii
);

    always_comb begin
        o_ascii = ASCII_UNKNOWN;
        case (i_code)
            {3'd2, 5'b00001}: o_ascii = 8'h41; // A .-
            {3'd4, 5'b01000}: o_ascii = 8'h42; // B -...
            {3'd4, 5'b01010}: o_ascii = 8'h43; // C -.-.
            {3'd3, 5'b00100}: o_ascii = 8'h44; // D -..
            {3'd1, 5'b00000}: o_ascii = 8'h45; // E .
            {3'd4, 5'b00010}: o_ascii = 8'h46; // F ..-.
            {3'd3, 5'b00110}: o_ascii = 8'h47; // G --.
            {3'd4, 5'b00000}: o_ascii = 8'h48; // H ....
            {3'd2, 5'b00000}: o_ascii = 8'h49; // I ..
            {3'd4, 5'b00111}: o_ascii = 8'h4A; // J .---
            {3'd3, 5'b00101}: o_ascii = 8'h4B; // K -.-
            {3'd4, 5'b00100}: o_ascii = 8'h4C; // L .-..
            {3'd2, 5'b00011}: o_ascii = 8'h4D; // M --
            {3'd2, 5'b00010}: o_ascii = 8'h4E; // N -.
            {3'd3, 5'b00111}: o_ascii = 8'h4F; // O ---
            {3'd4, 5'b00110}: o_ascii = 8'h50; // P .--.
            {3'd4, 5'b01101}: o_ascii = 8'h51; // Q --.-
            {3'd3, 5'b00010}: o_ascii = 8'h52; // R .-.
            {3'd3, 5'b00000}: o_ascii = 8'h53; // S ...
            {3'd1, 5'b00001}: o_ascii = 8'h54; // T -
            {3'd3, 5'b00001}: o_ascii = 8'h55; // U ..-
            {3'd4, 5'b00001}: o_ascii = 8'h56; // V ...-
            {3'd3, 5'b00011}: o_ascii = 8'h57; // W .--
            {3'd4, 5'b01001}: o_ascii = 8'h58; // X -..-
            {3'd4, 5'b01011}: o_ascii = 8'h59; // Y -.--
            {3'd4, 5'b01100}: o_ascii = 8'h5A; // Z --..
            {3'd5, 5'b11111}: o_ascii = 8'h30; // 0
            {3'd5, 5'b01111}: o_ascii = 8'h31; // 1
            {3'd5, 5'b00111}: o_ascii = 8'h32; // 2
            {3'd5, 5'b00011}: o_ascii = 8'h33; // 3
            {3'd5, 5'b00001}: o_ascii = 8'h34; // 4
            {3'd5, 5'b00000}: o_ascii = 8'h35; // 5
            {3'd5, 5'b10000}: o_ascii = 8'h36; // 6
            {3'd5, 5'b11000}: o_ascii = 8'h37; // 7
            {3'd5, 5'b11100}: o_ascii = 8'h38; // 8
            {3'd5, 5'b11110}: o_ascii = 8'h39; // 9
            default:          o_ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Straight-key Morse receiver: times marks/gaps in dot units, emits ASCII.
// Ports: i_clk, i_rst_n, bus (i_tick, i_key in; o_char, o_valid, o_busy out).
module morse_decoder
    import morse_pkg::*;
#(
    parameter int CNT_WIDTH      = 4,
    parameter int DASH_MIN       = 2,
    parameter int LETTER_GAP_MIN = 2,
    parameter int WORD_GAP_MIN   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    morse_decoder_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] DASH_TH = CNT_WIDTH'(DASH_MIN);
    localparam logic [CNT_WIDTH-1:0] LG_LAST = CNT_WIDTH'(LETTER_GAP_MIN - 1);
    localparam logic [CNT_WIDTH-1:0] WG_LAST = CNT_WIDTH'(WORD_GAP_MIN - 1);
    localparam logic [2:0]           E_LAST  = 3'(MAX_ELEMS);

    logic key_s1;
    logic key_s2;
    logic key_d;
    logic key_rise;
    logic key_fall;

    state_t state;
    state_t state_n;

    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           elem_cnt;
    logic [4:0]           pattern;
    logic                 ovf;

    logic   store;
    elem_t  elem;
    logic   emit_chr;
    logic   emit_spc;
    logic   keep_cnt;
    logic   cnt_clr;
    ascii_t lut_char;
    code_t  code;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_d  <= 1'b0;
        end else begin
            key_s1 <= bus.i_key;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    assign key_rise = key_s2 & ~key_d;
    assign key_fall = ~key_s2 & key_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Key rise is checked first so it beats a same-cycle gap tick.
    always_comb begin
        state_n  = state;
        store    = 1'b0;
        elem     = DOT;
        emit_chr = 1'b0;
        emit_spc = 1'b0;
        keep_cnt = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_rise) begin
                    state_n = MARK;
                end
            end
            MARK: begin
                if (key_fall) begin
                    store   = 1'b1;
                    elem    = (cnt >= DASH_TH) ? DASH : DOT;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (key_rise) begin
                    state_n = MARK;
                end else if (bus.i_tick && cnt == LG_LAST) begin
                    emit_chr = 1'b1;
                    keep_cnt = 1'b1;
                    state_n  = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (key_rise) begin
                    state_n = MARK;
                end else if (bus.i_tick && cnt == WG_LAST) begin
                    emit_spc = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Word gap is timed from the end of the last mark, so the
    // GAP -> WAIT_WORD move keeps the running count.
    assign cnt_clr = (state_n != state) && !keep_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (bus.i_tick && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            elem_cnt <= '0;
            pattern  <= '0;
            ovf      <= 1'b0;
        end else if (store) begin
            if (elem_cnt == E_LAST) begin
                ovf <= 1'b1;
            end else begin
                pattern  <= {pattern[3:0], elem};
                elem_cnt <= elem_cnt + 1'b1;
            end
        end else if (emit_chr) begin
            elem_cnt <= '0;
            pattern  <= '0;
            ovf      <= 1'b0;
        end
    end

    assign code.len = elem_cnt;
    assign code.pat = pattern;

    morse_lut u_lut (
        .i_code  (code),
        .o_ascii (lut_char)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_char  <= '0;
        end else begin
            bus.o_valid <= emit_chr | emit_spc;
            if (emit_spc) begin
                bus.o_char <= ASCII_SPACE;
            end else if (emit_chr) begin
                bus.o_char <= ovf ? ASCII_UNKNOWN : lut_char;
            end
        end
    end

    assign bus.o_busy = (state == MARK) || (state == GAP);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: letters, digits, overflow, reset.
// One tick every 4 clocks; keying is laid out in whole tick units.
module tb_morse_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] q[$];

    morse_decoder_if bus ();

    morse_decoder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Log every strobe; o_valid is one cycle wide so one negedge sees it.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) q.push_back(bus.o_char);
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One unit: tick in the first of four cycles, key held at k.
    task automatic units(input int n, input logic k);
        for (int u = 0; u < n; u++) begin
            bus.i_key  = k;
            bus.i_tick = 1'b1;
            @(negedge clk);
            bus.i_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Marks with 1-unit intra-character gaps; ends on the last mark.
    task automatic send(input string code);
        for (int i = 0; i < code.len(); i++) begin
            units((code[i] == 8'h2D) ? 3 : 1, 1'b1);
            if (i != code.len() - 1) units(1, 1'b0);
        end
    endtask

    initial begin
        bus.i_key  = 1'b0;
        bus.i_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst char", bus.o_char, 8'h00);
        check("rst valid", bus.o_valid, 1'b0);
        check("rst busy", bus.o_busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "A" with cycle-exact emission checks
        q.delete();
        units(1, 1'b1);
        units(1, 1'b0);
        units(3, 1'b1);
        units(2, 1'b0);
        check("A busy pre", bus.o_busy, 1'b1);
        check("A no early", bus.o_valid, 1'b0);
        bus.i_tick = 1'b1;
        @(negedge clk);
        check("A valid", bus.o_valid, 1'b1);
        check("A char", bus.o_char, 8'h41);
        bus.i_tick = 1'b0;
        @(negedge clk);
        check("A pulse 1cyc", bus.o_valid, 1'b0);
        repeat (2) @(negedge clk);
        check("A busy post", bus.o_busy, 1'b0);
        units(2, 1'b0);
        bus.i_tick = 1'b1;
        @(negedge clk);
        check("A sp valid", bus.o_valid, 1'b1);
        check("A sp char", bus.o_char, 8'h20);
        bus.i_tick = 1'b0;
        repeat (3) @(negedge clk);
        units(4, 1'b0);
        check("A strobes", q.size(), 2);
        check("A q0", q[0], 8'h41);
        check("A q1", q[1], 8'h20);
        check("A char hold", bus.o_char, 8'h20);

        // "SOS" with 3-unit letter gaps
        q.delete();
        send("...");
        units(3, 1'b0);
        check("SOS busy1", bus.o_busy, 1'b0);
        send("---");
        units(3, 1'b0);
        check("SOS busy2", bus.o_busy, 1'b0);
        send("...");
        units(8, 1'b0);
        check("SOS strobes", q.size(), 4);
        check("SOS q0", q[0], 8'h53);
        check("SOS q1", q[1], 8'h4F);
        check("SOS q2", q[2], 8'h53);
        check("SOS q3", q[3], 8'h20);

        // Six dots overflow
        q.delete();
        send("......");
        units(8, 1'b0);
        check("ovf strobes", q.size(), 2);
        check("ovf q0", q[0], 8'h3F);
        check("ovf q1", q[1], 8'h20);

        // Unknown ..--
        q.delete();
        send("..--");
        units(8, 1'b0);
        check("unk strobes", q.size(), 2);
        check("unk q0", q[0], 8'h3F);

        // Digit 5
        q.delete();
        send(".....");
        units(8, 1'b0);
        check("5 strobes", q.size(), 2);
        check("5 q0", q[0], 8'h35);

        // Long mark saturates and decodes as T
        q.delete();
        units(18, 1'b1);
        check("sat cnt", 32'(dut.cnt), 15);
        check("sat busy", bus.o_busy, 1'b1);
        units(2, 1'b1);
        units(8, 1'b0);
        check("T strobes", q.size(), 2);
        check("T q0", q[0], 8'h54);

        // Reset mid-GAP after .-
        q.delete();
        send(".-");
        units(1, 1'b0);
        check("mid busy", bus.o_busy, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid rst char", bus.o_char, 8'h00);
        check("mid rst busy", bus.o_busy, 1'b0);
        rst_n = 1'b1;
        units(8, 1'b0);
        check("mid strobes", q.size(), 0);
        check("mid char", bus.o_char, 8'h00);
        check("mid valid", bus.o_valid, 1'b0);
        check("mid busy2", bus.o_busy, 1'b0);
        send(".");
        units(8, 1'b0);
        check("E strobes", q.size(), 2);
        check("E q0", q[0], 8'h45);
        check("E q1", q[1], 8'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
